// File: rtl/demod_pkg.sv
// demod_pkg: shared definitions for the demodulator control slice.
//   mode_t  : demodulator output selection carried on cfg_mode / out_mode
//   state_t : sequencer states (IDLE, APPLY, SETTLE, RUN)
//   SETTLE_SAMPLES_DEF : default number of strobes discarded after a retune
package demod_pkg;

   typedef enum logic [1:0] {
      MODE_AM   = 2'd0,
      MODE_PM   = 2'd1,
      MODE_FM   = 2'd2,
      MODE_RSVD = 2'd3
   } mode_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_APPLY,
      ST_SETTLE,
      ST_RUN
   } state_t;

   localparam int unsigned SETTLE_SAMPLES_DEF = 8;

endpackage

// File: rtl/demod_ctrl_if.sv
// demod_ctrl_if: configuration request channel and demodulated sample stream.
//   cfg_valid/cfg_ready        : tuning command handshake
//   cfg_fre_word/cfg_n/cfg_mode: tuning command payload
//   out_valid/out_ready        : sample stream handshake
//   out_data/out_mode          : selected sample and its mode tag
// master = host side (issues commands, consumes samples); slave = demod_ctrl.
interface demod_ctrl_if #(
   parameter int unsigned PHASE_WIDTH  = 32,
   parameter int unsigned OUTPUT_WIDTH = 24
);
   logic                    cfg_valid;
   logic                    cfg_ready;
   logic [PHASE_WIDTH-1:0]  cfg_fre_word;
   logic [15:0]             cfg_n;
   logic [1:0]              cfg_mode;
   logic                    out_valid;
   logic                    out_ready;
   logic [OUTPUT_WIDTH-1:0] out_data;
   logic [1:0]              out_mode;

   modport master (
      output cfg_valid, cfg_fre_word, cfg_n, cfg_mode, out_ready,
      input  cfg_ready, out_valid, out_data, out_mode
   );

   modport slave (
      input  cfg_valid, cfg_fre_word, cfg_n, cfg_mode, out_ready,
      output cfg_ready, out_valid, out_data, out_mode
   );
endinterface

// File: rtl/demod_out_buf.sv
// demod_out_buf: single-entry valid/ready output register.
//   clk_in, RST        : clock, synchronous active-high reset
//   load               : new sample offered this cycle
//   clr_ovf            : clear the sticky overflow flag
//   din, din_mode      : sample and mode tag to capture
//   out_ready          : downstream accept
//   out_valid/out_data/out_mode : buffered sample
//   ovf                : sticky, a load arrived while the entry was full and not draining
module demod_out_buf
   import demod_pkg::*;
#(
   parameter int unsigned WIDTH = 24
) (
   input  logic             clk_in,
   input  logic             RST,
   input  logic             load,
   input  logic             clr_ovf,
   input  logic [WIDTH-1:0] din,
   input  mode_t            din_mode,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output mode_t            out_mode,
   output logic             ovf
);

   logic blocked;

   // Entry cannot accept: full and the consumer is not taking it this cycle.
   assign blocked = out_valid && !out_ready;

   always_ff @(posedge clk_in) begin
      if (RST) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_mode  <= MODE_AM;
         ovf       <= 1'b0;
      end else begin
         if (load && blocked)
            ovf <= 1'b1;
         else if (clr_ovf)
            ovf <= 1'b0;

         if (load && !blocked) begin
            out_valid <= 1'b1;
            out_data  <= din;
            out_mode  <= din_mode;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/demod_ctrl.sv
// demod_ctrl: configuration and output sequencer for the IQ demodulator chain.
//   clk_in, RST : clock, synchronous active-high reset
//   bus         : tuning command channel and sample output stream
//   N, Fre_word : decimation and NCO frequency word driven to the demodulator
//   dem_stb     : one-cycle strobe, new am_in/pm_in/fm_in results present
//   busy        : retune in progress (APPLY or SETTLE)
//   ovf         : sticky, sample dropped because the output entry was full
//   cfg_err     : sticky, reserved mode requested
module demod_ctrl
   import demod_pkg::*;
#(
   parameter int unsigned PHASE_WIDTH    = 32,
   parameter int unsigned OUTPUT_WIDTH   = 24,
   parameter int unsigned SETTLE_SAMPLES = SETTLE_SAMPLES_DEF,
   parameter logic [15:0] N_RESET        = 16'd1
) (
   input  logic                    clk_in,
   input  logic                    RST,
   demod_ctrl_if.slave             bus,
   output logic [15:0]             N,
   output logic [PHASE_WIDTH-1:0]  Fre_word,
   input  logic                    dem_stb,
   input  logic [OUTPUT_WIDTH-1:0] am_in,
   input  logic [OUTPUT_WIDTH-1:0] pm_in,
   input  logic [OUTPUT_WIDTH-1:0] fm_in,
   output logic                    busy,
   output logic                    ovf,
   output logic                    cfg_err
);

   state_t                  state;
   mode_t                   mode_q;
   mode_t                   req_mode;
   mode_t                   buf_mode;
   logic [15:0]             settle_cnt;
   logic                    cfg_hs;
   logic                    retune;
   logic                    sample_load;
   logic [OUTPUT_WIDTH-1:0] sel_sample;

   assign req_mode      = mode_t'(bus.cfg_mode);
   assign bus.cfg_ready = !RST && (state != ST_APPLY);
   assign cfg_hs        = bus.cfg_valid && bus.cfg_ready;
   assign retune        = cfg_hs && (req_mode != MODE_RSVD);
   assign busy          = (state == ST_APPLY) || (state == ST_SETTLE);

   // A retune in the same cycle wins over the strobe.
   assign sample_load   = dem_stb && (state == ST_RUN) && !retune;

   always_comb begin
      sel_sample = am_in;
      case (mode_q)
         MODE_PM: sel_sample = pm_in;
         MODE_FM: sel_sample = fm_in;
         default: sel_sample = am_in;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (RST) begin
         state      <= ST_IDLE;
         mode_q     <= MODE_AM;
         N          <= N_RESET;
         Fre_word   <= '0;
         settle_cnt <= '0;
         cfg_err    <= 1'b0;
      end else if (retune) begin
         state    <= ST_APPLY;
         mode_q   <= req_mode;
         N        <= bus.cfg_n;
         Fre_word <= bus.cfg_fre_word;
         cfg_err  <= 1'b0;
      end else begin
         // Reserved-mode request only flags; the sequencer keeps running.
         if (cfg_hs)
            cfg_err <= 1'b1;
         case (state)
            ST_APPLY: begin
               settle_cnt <= 16'(SETTLE_SAMPLES);
               state      <= ST_SETTLE;
            end
            ST_SETTLE: begin
               if (dem_stb) begin
                  settle_cnt <= settle_cnt - 16'd1;
                  if (settle_cnt == 16'd1)
                     state <= ST_RUN;
               end
            end
            default: ;
         endcase
      end
   end

   demod_out_buf #(
      .WIDTH (OUTPUT_WIDTH)
   ) u_out_buf (
      .clk_in    (clk_in),
      .RST       (RST),
      .load      (sample_load),
      .clr_ovf   (retune),
      .din       (sel_sample),
      .din_mode  (mode_q),
      .out_ready (bus.out_ready),
      .out_valid (bus.out_valid),
      .out_data  (bus.out_data),
      .out_mode  (buf_mode),
      .ovf       (ovf)
   );

   assign bus.out_mode = buf_mode;

endmodule

// File: tb/tb_demod_ctrl.sv
module tb_demod_ctrl;
   localparam int PW     = 32;
   localparam int OW     = 24;
   localparam int SETTLE = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          dem_stb;
   logic [OW-1:0] am_in, pm_in, fm_in;
   logic [15:0]   N;
   logic [PW-1:0] Fre_word;
   logic          busy, ovf, cfg_err;

   always #5 clk = ~clk;

   demod_ctrl_if #(.PHASE_WIDTH(PW), .OUTPUT_WIDTH(OW)) bus ();

   demod_ctrl #(
      .PHASE_WIDTH    (PW),
      .OUTPUT_WIDTH   (OW),
      .SETTLE_SAMPLES (SETTLE),
      .N_RESET        (16'd1)
   ) dut (
      .clk_in   (clk),
      .RST      (rst),
      .bus      (bus.slave),
      .N        (N),
      .Fre_word (Fre_word),
      .dem_stb  (dem_stb),
      .am_in    (am_in),
      .pm_in    (pm_in),
      .fm_in    (fm_in),
      .busy     (busy),
      .ovf      (ovf),
      .cfg_err  (cfg_err)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: "configured" flag, a pending-apply flag, a count of
   // strobes still to discard, and a queue holding the buffered sample.
   bit            m_configured;
   bit            m_apply_pending;
   int            m_discard;
   logic [1:0]    m_mode;
   logic [15:0]   m_n;
   logic [PW-1:0] m_fre;
   bit            m_ovf, m_err;
   logic [OW-1:0] m_q[$];
   logic [OW-1:0] m_last_d;
   logic [1:0]    m_last_m;

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      bit            r, v, s, rdy, hs, run, exp_ready;
      logic [1:0]    md;
      logic [15:0]   cn;
      logic [PW-1:0] cf;
      logic [OW-1:0] smp;
      #1;
      r   = rst;  v = bus.cfg_valid; s = dem_stb; rdy = bus.out_ready;
      md  = bus.cfg_mode; cn = bus.cfg_n; cf = bus.cfg_fre_word;
      smp = (m_mode == 2'd1) ? pm_in : (m_mode == 2'd2) ? fm_in : am_in;
      exp_ready = !r && !m_apply_pending;
      chk("cfg_ready", {63'd0, bus.cfg_ready}, {63'd0, exp_ready});
      @(posedge clk);
      if (r) begin
         m_configured = 0; m_apply_pending = 0; m_discard = 0; m_mode = 0;
         m_n = 16'd1; m_fre = '0; m_ovf = 0; m_err = 0; m_q.delete();
         m_last_d = '0; m_last_m = 2'd0;
      end else begin
         hs = v && exp_ready;
         if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
         if (hs && md != 2'd3) begin
            m_n = cn; m_fre = cf; m_mode = md;
            m_apply_pending = 1; m_configured = 1; m_err = 0; m_ovf = 0;
         end else begin
            if (hs) m_err = 1;
            run = m_configured && !m_apply_pending && m_discard == 0;
            if (m_apply_pending) begin
               m_apply_pending = 0;
               m_discard = SETTLE;
            end else if (m_configured && m_discard > 0) begin
               if (s) m_discard--;
            end else if (run && s) begin
               if (m_q.size() > 0) m_ovf = 1;
               else begin
                  m_q.push_back(smp);
                  m_last_d = smp;
                  m_last_m = m_mode;
               end
            end
         end
      end
      #1;
      chk("N", {48'd0, N}, {48'd0, m_n});
      chk("Fre_word", {32'd0, Fre_word}, {32'd0, m_fre});
      chk("busy", {63'd0, busy},
          {63'd0, m_apply_pending || (m_configured && m_discard > 0)});
      chk("ovf", {63'd0, ovf}, {63'd0, m_ovf});
      chk("cfg_err", {63'd0, cfg_err}, {63'd0, m_err});
      chk("out_valid", {63'd0, bus.out_valid}, {63'd0, m_q.size() > 0});
      chk("out_data", {40'd0, bus.out_data}, {40'd0, m_last_d});
      chk("out_mode", {62'd0, bus.out_mode}, {62'd0, m_last_m});
   endtask

   task automatic rand_samples();
      am_in = OW'($urandom); pm_in = OW'($urandom); fm_in = OW'($urandom);
   endtask

   task automatic strobe(int n);
      for (int i = 0; i < n; i++) begin
         dem_stb = 1'b1;
         rand_samples();
         step();
      end
      dem_stb = 1'b0;
   endtask

   task automatic send_cfg(logic [PW-1:0] fw, logic [15:0] n, logic [1:0] md);
      bus.cfg_valid = 1'b1; bus.cfg_fre_word = fw; bus.cfg_n = n; bus.cfg_mode = md;
      step();
      bus.cfg_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; dem_stb = 1'b0; am_in = '0; pm_in = '0; fm_in = '0;
      bus.cfg_valid = 1'b0; bus.cfg_fre_word = '0; bus.cfg_n = '0;
      bus.cfg_mode = 2'd0; bus.out_ready = 1'b1;
      m_apply_pending = 0;
      step(); step();
      chk("rst_N", {48'd0, N}, 64'd1);
      chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      rst = 1'b0;

      // Strobes before any configuration produce nothing.
      strobe(4);
      chk("idle_no_out", {63'd0, bus.out_valid}, 64'd0);
      chk("idle_cfg_ready", {63'd0, bus.cfg_ready}, 64'd1);

      // AM tune: eight strobes discarded, ninth delivered.
      send_cfg(32'h1000_0000, 16'd16, 2'd0);
      chk("tune_N", {48'd0, N}, 64'd16);
      chk("tune_busy", {63'd0, busy}, 64'd1);
      step();
      strobe(SETTLE);
      chk("settle_no_out", {63'd0, bus.out_valid}, 64'd0);
      dem_stb = 1'b1; am_in = 24'h000123; step(); dem_stb = 1'b0;
      chk("am_first", {40'd0, bus.out_data}, 64'h123);
      chk("am_first_valid", {63'd0, bus.out_valid}, 64'd1);
      step();

      // FM: overflow while stalled, then drain.
      send_cfg(32'h0ABC_0000, 16'd4, 2'd2); step(); strobe(SETTLE);
      bus.out_ready = 1'b0;
      dem_stb = 1'b1; fm_in = 24'd5; step();
      fm_in = 24'hFFFFFD; step(); dem_stb = 1'b0;
      chk("fm_hold", {40'd0, bus.out_data}, 64'd5);
      chk("fm_ovf", {63'd0, ovf}, 64'd1);
      bus.out_ready = 1'b1; step();
      chk("fm_drained", {63'd0, bus.out_valid}, 64'd0);

      // Reload in the same cycle the held sample is consumed.
      send_cfg(32'h0ABC_0000, 16'd4, 2'd2); step(); strobe(SETTLE);
      dem_stb = 1'b1; fm_in = 24'd7; step();
      fm_in = 24'd9; step(); dem_stb = 1'b0;
      chk("reload_data", {40'd0, bus.out_data}, 64'd9);
      chk("reload_no_ovf", {63'd0, ovf}, 64'd0);

      // Reserved mode during RUN: flagged, sampling continues.
      dem_stb = 1'b1; fm_in = 24'd11;
      send_cfg(32'hDEAD_BEEF, 16'd99, 2'd3); dem_stb = 1'b0;
      chk("rsvd_err", {63'd0, cfg_err}, 64'd1);
      chk("rsvd_N", {48'd0, N}, 64'd4);
      chk("rsvd_sample", {40'd0, bus.out_data}, 64'd11);

      // Retune mid-SETTLE restarts the full discard window.
      send_cfg(32'h1111_0000, 16'd8, 2'd1); step(); strobe(5);
      send_cfg(32'h2222_0000, 16'd12, 2'd1); step(); strobe(SETTLE - 1);
      chk("restart_busy", {63'd0, busy}, 64'd1);
      strobe(1);
      chk("restart_done", {63'd0, busy}, 64'd0);
      bus.out_ready = 1'b0;
      strobe(1);
      chk("pm_held", {63'd0, bus.out_valid}, 64'd1);

      // Reset with a sample pending.
      rst = 1'b1; step(); rst = 1'b0;
      chk("rst_lost", {63'd0, bus.out_valid}, 64'd0);
      chk("rst_fre", {32'd0, Fre_word}, 64'd0);
      bus.out_ready = 1'b1;

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         rst           = ($urandom_range(0, 149) == 0);
         bus.cfg_valid = ($urandom_range(0, 24) == 0);
         bus.cfg_mode  = 2'($urandom_range(0, 3));
         bus.cfg_n     = 16'($urandom);
         bus.cfg_fre_word = PW'($urandom);
         dem_stb       = $urandom_range(0, 1) == 1;
         bus.out_ready = $urandom_range(0, 2) != 0;
         rand_samples();
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
